// File: rtl/toy_exec_pipe_if.sv
// Operation/result bundle between decode, the execute pipe and writeback.
// master = the side that issues operations and consumes results.
interface toy_exec_pipe_if #(
  parameter int DW     = 32,
  parameter int IMM_W  = 17,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
);
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [4:0]              IN_OP;
  logic [DW-1:0]           IN_A;
  logic [DW-1:0]           IN_B;
  logic [IMM_W-1:0]        IN_IMM;
  logic [TAG_W-1:0]        IN_TAG;
  logic                    IN_WER;
  logic                    FLUSH;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic [DW-1:0]           OUT_RESULT;
  logic [TAG_W-1:0]        OUT_TAG;
  logic                    OUT_WER;
  logic                    OUT_ILLEGAL;
  logic [STAGES-1:0]       PEND_VLD;
  logic [STAGES*TAG_W-1:0] PEND_TAG;

  modport master (
    output IN_VALID, IN_OP, IN_A, IN_B, IN_IMM, IN_TAG, IN_WER, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG, OUT_WER, OUT_ILLEGAL, PEND_VLD, PEND_TAG
  );

  modport slave (
    input  IN_VALID, IN_OP, IN_A, IN_B, IN_IMM, IN_TAG, IN_WER, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG, OUT_WER, OUT_ILLEGAL, PEND_VLD, PEND_TAG
  );
endinterface

// File: rtl/toy_exec_pipe.sv
// RISC_TOY execute stage: combinational ALU/address compute feeding an
// elastic, bubble-collapsing register pipeline of STAGES entries. The last
// stage drives the result port; every stage reports its pending write tag.
module toy_exec_pipe #(
  parameter int DW     = 32,
  parameter int IMM_W  = 17,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input logic             CLK,
  input logic             RSTN,
  toy_exec_pipe_if.slave  bus
);
  localparam int SHW = $clog2(DW);

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  logic [DW-1:0]    sx;
  logic [SHW-1:0]   sh;
  logic [DW-1:0]    alu_res;
  logic             alu_ill;
  logic             alu_wer;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] wer_q;
  logic [STAGES-1:0] ill_q;
  logic [DW-1:0]     res_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_wer;
  logic [STAGES-1:0] src_ill;
  logic [DW-1:0]     src_res [STAGES];
  logic [TAG_W-1:0]  src_tag [STAGES];

  assign sx = DW'($signed(bus.IN_IMM));
  assign sh = bus.IN_B[SHW-1:0];

  // Decode the opcode and compute the result of the offered operation.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (bus.IN_OP)
      OP_ADDI: alu_res = bus.IN_A + sx;
      OP_ANDI: alu_res = bus.IN_A & sx;
      OP_ORI:  alu_res = bus.IN_A | sx;
      OP_MOVI: alu_res = sx;
      OP_ADD:  alu_res = bus.IN_A + bus.IN_B;
      OP_SUB:  alu_res = bus.IN_A - bus.IN_B;
      OP_NEG:  alu_res = -bus.IN_B;
      OP_NOT:  alu_res = ~bus.IN_B;
      OP_AND:  alu_res = bus.IN_A & bus.IN_B;
      OP_OR:   alu_res = bus.IN_A | bus.IN_B;
      OP_XOR:  alu_res = bus.IN_A ^ bus.IN_B;
      OP_LSR:  alu_res = bus.IN_A >> sh;
      OP_ASR:  alu_res = $signed(bus.IN_A) >>> sh;
      OP_SHL:  alu_res = bus.IN_A << sh;
      // A left shift by DW yields zero, so sh=0 returns A unchanged.
      OP_ROR:  alu_res = (bus.IN_A >> sh) | (bus.IN_A << (DW - int'(sh)));
      OP_LD, OP_LDR, OP_ST, OP_STR: alu_res = bus.IN_A + sx;
      default: alu_ill = 1'b1;
    endcase
    alu_wer = bus.IN_WER && !alu_ill && (bus.IN_OP != OP_ST) && (bus.IN_OP != OP_STR);
  end

  // A stage can take new data if it is empty or its own content moves on;
  // this lets bubbles collapse so a stalled tail still fills up.
  always_comb begin
    logic nxt;
    acc = '0;
    nxt = !v_q[STAGES-1] || bus.OUT_READY;
    acc[STAGES-1] = nxt;
    for (int i = STAGES - 2; i >= 0; i--) begin
      nxt = !v_q[i] || nxt;
      acc[i] = nxt;
    end
  end

  // Source of each stage: the ALU for stage 0, the previous stage otherwise.
  always_comb begin
    src_v[0]   = bus.IN_VALID;
    src_wer[0] = alu_wer;
    src_ill[0] = alu_ill;
    src_res[0] = alu_res;
    src_tag[0] = bus.IN_TAG;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i]   = v_q[i-1];
      src_wer[i] = wer_q[i-1];
      src_ill[i] = ill_q[i-1];
      src_res[i] = res_q[i-1];
      src_tag[i] = tag_q[i-1];
    end
  end

  // Stage registers: advance when accepting, flush clears only valid bits.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v_q   <= '0;
      wer_q <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (bus.FLUSH) begin
          v_q[i] <= 1'b0;
        end else if (acc[i]) begin
          v_q[i] <= src_v[i];
        end
        if (acc[i] && src_v[i]) begin
          wer_q[i] <= src_wer[i];
          ill_q[i] <= src_ill[i];
          res_q[i] <= src_res[i];
          tag_q[i] <= src_tag[i];
        end
      end
    end
  end

  assign bus.IN_READY    = acc[0];
  assign bus.OUT_VALID   = v_q[STAGES-1];
  assign bus.OUT_RESULT  = res_q[STAGES-1];
  assign bus.OUT_TAG     = tag_q[STAGES-1];
  assign bus.OUT_WER     = wer_q[STAGES-1];
  assign bus.OUT_ILLEGAL = ill_q[STAGES-1];
  assign bus.PEND_VLD    = v_q & wer_q;

  // Flatten per-stage tags for the hazard detector in decode.
  always_comb begin
    bus.PEND_TAG = '0;
    for (int i = 0; i < STAGES; i++) begin
      bus.PEND_TAG[i*TAG_W +: TAG_W] = tag_q[i];
    end
  end
endmodule
